// File: rtl/seg_scan_ctrl_pkg.sv
// Shared constants and scan-state type for the multiplexed 7-segment scanner.
// Imported by seg_scan_ctrl and digit_buffer.
package seg_pkg;

    localparam logic [3:0] SEG_BLANK = 4'hF;
    localparam logic [3:0] SEG_DOT   = 4'hA;
    localparam logic [3:0] SEG_U     = 4'hB;

    typedef enum logic [0:0] {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

endpackage

// File: rtl/seg_scan_ctrl_digit_buffer.sv
// Keypad digit buffer: shift-in at entry 0, backspace, clear; priority clr > del > key.
// key_ready drops combinationally whenever clr/del is present so a concurrent key is held off.
module digit_buffer
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    key_valid,
    input  logic [3:0]              key_code,
    output logic                    key_ready,
    input  logic                    key_del,
    input  logic                    clr,
    output logic [NUM_DIGITS*4-1:0] entries
);

    localparam int W = NUM_DIGITS * 4;

    logic [W-1:0] entries_q;
    logic [W-1:0] entries_d;

    assign key_ready = !rst && !clr && !key_del;
    assign entries   = entries_q;

    always_comb begin
        entries_d = entries_q;
        if (clr) begin
            entries_d = {NUM_DIGITS{SEG_BLANK}};
        end else if (key_del) begin
            entries_d = {SEG_BLANK, entries_q[W-1:4]};
        end else if (key_valid && key_ready) begin
            entries_d = {entries_q[W-5:0], key_code};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entries_q <= {NUM_DIGITS{SEG_BLANK}};
        end else begin
            entries_q <= entries_d;
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Scans NUM_DIGITS common-anode digits through one shared decoder, blanking each slot's start.
// Define SEG_LZ_BLANK_EN to suppress leading zeros on bcd_out.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          key_valid,
    input  logic [3:0]                    key_code,
    output logic                          key_ready,
    input  logic                          key_del,
    input  logic                          clr,
    output logic [3:0]                    bcd_out,
    output logic [NUM_DIGITS-1:0]         an_out,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int CNT_W = $clog2(SCAN_DIV);

    logic [NUM_DIGITS*4-1:0] entries_w;

    digit_buffer #(
        .NUM_DIGITS (NUM_DIGITS)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_ready (key_ready),
        .key_del   (key_del),
        .clr       (clr),
        .entries   (entries_w)
    );

    scan_state_t           state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [3:0]            bcd_q, bcd_d;
    logic [3:0]            disp [NUM_DIGITS];
    logic                  sig_seen;

    // Display value per position, after optional leading-zero suppression.
    always_comb begin
        sig_seen = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            disp[i] = entries_w[i*4 +: 4];
`ifdef SEG_LZ_BLANK_EN
            if (i != 0 && entries_w[i*4 +: 4] == 4'h0 && !sig_seen) begin
                disp[i] = SEG_BLANK;
            end
`endif
            if (entries_w[i*4 +: 4] != 4'h0 && entries_w[i*4 +: 4] != SEG_BLANK) begin
                sig_seen = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        idx_d   = idx_q;
        case (state_q)
            BLANK: begin
                if (cnt_q == CNT_W'(BLANK_CYCLES - 1)) begin
                    state_d = SHOW;
                end
            end
            SHOW: begin
                if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
                    state_d = BLANK;
                    cnt_d   = '0;
                    idx_d   = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
                end
            end
            default: begin
                state_d = BLANK;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase

        // Outputs are built from next-state so the registers line up with the FSM.
        an_d = '1;
        if (state_d == SHOW) begin
            an_d[idx_d] = 1'b0;
        end
        bcd_d = disp[idx_d];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BLANK;
            cnt_q   <= '0;
            idx_q   <= '0;
            an_q    <= '1;
            bcd_q   <= SEG_BLANK;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            bcd_q   <= bcd_d;
        end
    end

    assign bcd_out   = bcd_q;
    assign an_out    = an_q;
    assign digit_idx = idx_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl with NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2.
module tb_seg_scan_ctrl;

    localparam int N  = 4;
    localparam int SD = 8;
    localparam int BC = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         key_valid = 1'b0;
    logic [3:0]   key_code = 4'h0;
    logic         key_del = 1'b0;
    logic         clr = 1'b0;
    logic         key_ready;
    logic [3:0]   bcd_out;
    logic [N-1:0] an_out;
    logic [1:0]   digit_idx;

    seg_scan_ctrl #(
        .NUM_DIGITS   (N),
        .SCAN_DIV     (SD),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_ready (key_ready),
        .key_del   (key_del),
        .clr       (clr),
        .bcd_out   (bcd_out),
        .an_out    (an_out),
        .digit_idx (digit_idx)
    );

    always #5 clk = ~clk;

    int vec = 0;
    int mis = 0;
    int t   = 0;
    int mbuf  [N];
    int mprev [N];

    typedef struct {
        logic        kv;
        logic [3:0]  kc;
        logic        del;
        logic        c;
        logic        rdy;
        logic [15:0] ebuf;
    } vec_t;

    vec_t tbl [20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            mis++;
            $display("FAIL %s t=%0d actual=%0h required=%0h", name, t, act, exp);
        end
    endtask

    // What the display should show for position i given the buffer contents.
    function automatic int disp(input int i);
        int ms;
        ms = -1;
        for (int j = 0; j < N; j++)
            if (mprev[j] != 0 && mprev[j] != 15) ms = j;
`ifdef SEG_LZ_BLANK_EN
        if (i > 0 && i > ms && mprev[i] == 0) return 15;
`endif
        return mprev[i];
    endfunction

    task automatic model_reset();
        t = 0;
        for (int i = 0; i < N; i++) begin
            mbuf[i]  = 15;
            mprev[i] = 15;
        end
    endtask

    // Called at a negedge: check outputs for cycle t, drive inputs, advance model one clock.
    task automatic step(input logic kv, input logic [3:0] kc, input logic del, input logic c);
        int  idx;
        bit  show;
        idx  = (t / SD) % N;
        show = (t % SD) >= BC;
        chk("an_out", an_out, show ? ((~(32'd1 << idx)) & 32'hF) : 32'hF);
        chk("bcd_out", bcd_out, disp(idx));
        chk("digit_idx", digit_idx, idx);
        key_valid = kv;
        key_code  = kc;
        key_del   = del;
        clr       = c;
        #1;
        chk("key_ready", key_ready, (del || c) ? 0 : 1);
        mprev = mbuf;
        if (c) begin
            for (int i = 0; i < N; i++) mbuf[i] = 15;
        end else if (del) begin
            for (int i = 0; i < N - 1; i++) mbuf[i] = mbuf[i+1];
            mbuf[N-1] = 15;
        end else if (kv) begin
            for (int i = N - 1; i > 0; i--) mbuf[i] = mbuf[i-1];
            mbuf[0] = kc;
        end
        t++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 4'h0, 0, 0);
    endtask

    task automatic wait_show(input int d);
        bit ok;
        ok = 0;
        for (int k = 0; k < 64 && !ok; k++) begin
            if (digit_idx == d && an_out == 4'((~(32'd1 << d)) & 32'hF)) ok = 1;
            else idle(1);
        end
        if (!ok) chk("wait_show_timeout", 0, 1);
    endtask

    task automatic do_reset();
        key_valid = 0; key_del = 0; clr = 0; key_code = 0;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_an", an_out, 4'hF);
        chk("rst_bcd", bcd_out, 4'hF);
        chk("rst_idx", digit_idx, 0);
        chk("rst_ready", key_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    logic [3:0] lz_exp [N];

    initial begin
        tbl[0]  = '{0, 4'h0, 0, 1, 0, 16'hFFFF};
        tbl[1]  = '{1, 4'h1, 0, 0, 1, 16'hFFF1};
        tbl[2]  = '{1, 4'h2, 0, 0, 1, 16'hFF12};
        tbl[3]  = '{1, 4'h3, 0, 0, 1, 16'hF123};
        tbl[4]  = '{1, 4'h4, 0, 0, 1, 16'h1234};
        tbl[5]  = '{0, 4'h0, 1, 0, 0, 16'hF123};
        tbl[6]  = '{0, 4'h0, 0, 1, 0, 16'hFFFF};
        tbl[7]  = '{1, 4'h1, 0, 0, 1, 16'hFFF1};
        tbl[8]  = '{1, 4'h2, 0, 0, 1, 16'hFF12};
        tbl[9]  = '{1, 4'h3, 0, 0, 1, 16'hF123};
        tbl[10] = '{1, 4'h4, 0, 0, 1, 16'h1234};
        tbl[11] = '{1, 4'h5, 0, 0, 1, 16'h2345};
        tbl[12] = '{1, 4'h7, 0, 1, 0, 16'hFFFF};
        tbl[13] = '{1, 4'h7, 0, 0, 1, 16'hFFF7};
        tbl[14] = '{1, 4'h0, 0, 0, 1, 16'hFF70};
        tbl[15] = '{1, 4'h9, 1, 0, 0, 16'hFFF7};
        tbl[16] = '{1, 4'hE, 0, 0, 1, 16'hFF7E};
        tbl[17] = '{1, 4'hA, 0, 0, 1, 16'hF7EA};
        tbl[18] = '{0, 4'h0, 1, 1, 0, 16'hFFFF};
        tbl[19] = '{0, 4'h0, 0, 0, 1, 16'hFFFF};

`ifdef SEG_LZ_BLANK_EN
        lz_exp[3] = 4'hF; lz_exp[2] = 4'hF; lz_exp[1] = 4'h4; lz_exp[0] = 4'h0;
`else
        lz_exp[3] = 4'h0; lz_exp[2] = 4'h0; lz_exp[1] = 4'h4; lz_exp[0] = 4'h0;
`endif

        do_reset();
        // Idle scan: two full rounds plus one slot.
        idle(N * SD * 2 + SD);

        // Buffer operations, one row per cycle.
        for (int r = 0; r < 20; r++) begin
            step(tbl[r].kv, tbl[r].kc, tbl[r].del, tbl[r].c);
            chk("row_ready", key_ready, tbl[r].rdy);
            chk("row_entries", dut.entries_w, tbl[r].ebuf);
        end

        // Keys 1..5 then digit 0 in SHOW must display 5.
        step(0, 4'h0, 0, 1);
        for (int k = 1; k <= 5; k++) step(1, 4'(k), 0, 0);
        idle(1);
        wait_show(0);
        chk("digit0_shows_5", bcd_out, 4'h5);
        chk("digit0_anode", an_out, 4'b1110);

        // Leading-zero pattern {0,0,4,0}.
        step(0, 4'h0, 0, 1);
        step(1, 4'h0, 0, 0);
        step(1, 4'h0, 0, 0);
        step(1, 4'h4, 0, 0);
        step(1, 4'h0, 0, 0);
        idle(1);
        for (int d = N - 1; d >= 0; d--) begin
            wait_show(d);
            chk("lz_digit", bcd_out, lz_exp[d]);
        end

        // Reset asserted mid-SHOW of digit 2.
        wait_show(2);
        idle(1);
        rst = 1'b1;
        #1;
        chk("midrst_an", an_out, 4'hF);
        chk("midrst_bcd", bcd_out, 4'hF);
        chk("midrst_idx", digit_idx, 0);
        chk("midrst_ready", key_ready, 0);
        key_valid = 0; key_del = 0; clr = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        idle(SD + 2);

        // Random traffic against the model.
        for (int k = 0; k < 400; k++) begin
            step($urandom_range(0, 1), 4'($urandom_range(0, 15)),
                 $urandom_range(0, 9) == 0, $urandom_range(0, 14) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout t=%0d actual=running required=finished", t);
        $fatal(1);
    end

endmodule
